// File: rtl/ld_write_arbiter_pkg.sv
`default_nettype none
// ld_pkg: shared constants, data types and arbiter states for ld_write_arbiter.
// Revision 1.0
package ld_pkg;

  localparam int LD_N_REQ = 4;
  localparam int LD_DEPTH = 8;
  localparam int LD_DW    = 20;
  localparam int LD_AW    = 4;

  typedef logic [LD_DW-1:0] ld_data_t;
  typedef logic [LD_AW-1:0] ld_addr_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } ld_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/ld_write_arbiter_if.sv
`default_nettype none
// ld_write_arbiter_if: requester, clear-control and register-file write signals.
// Revision 1.0; carries err only when LD_ADDR_CHECK_EN is defined.
interface ld_write_arbiter_if
  import ld_pkg::*;
#(
  parameter int N_REQ = LD_N_REQ,
  parameter int DW    = LD_DW,
  parameter int AW    = LD_AW
) ();

  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    ack;
  logic                clear_start;
  logic                busy;
  logic                clear_done;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;

`ifdef LD_ADDR_CHECK_EN
  logic [N_REQ-1:0]    err;

  modport master (
    output req, req_addr, req_data, clear_start,
    input  ack, busy, clear_done, wr_en, wr_addr, wr_data, err
  );

  modport slave (
    input  req, req_addr, req_data, clear_start,
    output ack, busy, clear_done, wr_en, wr_addr, wr_data, err
  );
`else
  modport master (
    output req, req_addr, req_data, clear_start,
    input  ack, busy, clear_done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req, req_addr, req_data, clear_start,
    output ack, busy, clear_done, wr_en, wr_addr, wr_data
  );
`endif

endinterface
`default_nettype wire

// File: rtl/ld_write_arbiter_rr_pick.sv
`default_nettype none
// rr_pick: combinational round-robin picker, first eligible index at or after rr_ptr.
// Revision 1.0
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    winner,
  output logic             any_valid
);

  logic [IW-1:0] idx;

  // Scanning from the farthest offset down lets the nearest eligible index win last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % N_REQ);
      if (eligible[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ld_write_arbiter.sv
`default_nettype none
// ld_write_arbiter: one-write-per-cycle round-robin arbiter plus full-table clear sequencer.
// Revision 1.0; optional address range check under LD_ADDR_CHECK_EN (adds err).
module ld_write_arbiter
  import ld_pkg::*;
#(
  parameter int N_REQ = LD_N_REQ,
  parameter int DEPTH = LD_DEPTH,
  parameter int DW    = LD_DW,
  parameter int AW    = LD_AW
) (
  input  logic               clk,
  input  logic               rst,
  ld_write_arbiter_if.slave  bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  ld_arb_state_e    state, state_nxt;
  logic [IW-1:0]    rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]    clr_cnt, clr_cnt_nxt;
  logic [N_REQ-1:0] ack_q, ack_nxt;
  logic             wr_en_q, wr_en_nxt;
  logic [AW-1:0]    wr_addr_q, wr_addr_nxt;
  logic [DW-1:0]    wr_data_q, wr_data_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;

  logic [N_REQ-1:0] eligible;
  logic [IW-1:0]    winner;
  logic             any_valid;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_data;

`ifdef LD_ADDR_CHECK_EN
  logic [N_REQ-1:0] err_q, err_nxt;
`endif

  // A requester acked this cycle still shows req; masking it prevents a double write.
  assign eligible = bus.req & ~ack_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign win_addr = bus.req_addr[int'(winner)*AW +: AW];
  assign win_data = bus.req_data[int'(winner)*DW +: DW];

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    clr_cnt_nxt = clr_cnt;
    ack_nxt     = '0;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = '0;
    wr_data_nxt = '0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
`ifdef LD_ADDR_CHECK_EN
    err_nxt     = '0;
`endif
    case (state)
      RUN: begin
        if (bus.clear_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
          wr_en_nxt   = 1'b1;
          busy_nxt    = 1'b1;
        end else if (any_valid) begin
          rr_ptr_nxt      = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
          ack_nxt[winner] = 1'b1;
`ifdef LD_ADDR_CHECK_EN
          if (32'(win_addr) >= DEPTH) begin
            err_nxt[winner] = 1'b1;
          end else begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = win_addr;
            wr_data_nxt = win_data;
          end
`else
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = win_addr;
          wr_data_nxt = win_data;
`endif
        end
      end
      CLEAR: begin
        // clr_cnt holds the address being written in the current cycle.
        if (clr_cnt == CNT_LAST) begin
          state_nxt   = RUN;
          clr_cnt_nxt = '0;
          done_nxt    = 1'b1;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = AW'(clr_cnt + 1'b1);
          busy_nxt    = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      rr_ptr    <= '0;
      clr_cnt   <= '0;
      ack_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      clr_cnt   <= clr_cnt_nxt;
      ack_q     <= ack_nxt;
      wr_en_q   <= wr_en_nxt;
      wr_addr_q <= wr_addr_nxt;
      wr_data_q <= wr_data_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

`ifdef LD_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_nxt;
    end
  end

  assign bus.err = err_q;
`endif

  assign bus.ack        = ack_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.clear_done = done_q;

endmodule
`default_nettype wire
